// File: rtl/rx_frame_controller_pkg.sv
// Shared types, constants and the RATE to N_DBPS mapping for the receive frame controller.
package rx_frame_controller_pkg;

  localparam logic [11:0] HEADER_DEFAULT = 12'hFFF;

  localparam int unsigned SIG_LEN   = 18;
  localparam int unsigned TAIL_LEN  = 6;
  localparam int unsigned SVC_LEN   = 16;
  localparam int unsigned SEED_LEN  = 7;

  localparam int unsigned HDR_W     = 12;
  localparam int unsigned RATE_W    = 4;
  localparam int unsigned LEN_W     = 12;
  localparam int unsigned BIT_CNT_W = 16;
  localparam int unsigned SYM_CNT_W = 8;
  localparam int unsigned LFSR_W    = 7;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_SIG,
    ST_SIG_TAIL,
    ST_SERVICE,
    ST_DATA,
    ST_TAIL,
    ST_PAD
  } state_t;

  // SIGNAL field without the parity bit, which only feeds the running XOR
  typedef struct packed {
    logic [RATE_W-1:0] rate;
    logic              rsvd;
    logic [LEN_W-1:0]  length;
  } sig_hdr_t;

  function automatic logic [SYM_CNT_W-1:0] ndbps(input logic [RATE_W-1:0] rate);
    case (rate)
      4'b1101: ndbps = 8'd24;
      4'b1111: ndbps = 8'd36;
      4'b0101: ndbps = 8'd48;
      4'b0111: ndbps = 8'd72;
      4'b1001: ndbps = 8'd96;
      4'b1011: ndbps = 8'd144;
      4'b0001: ndbps = 8'd192;
      4'b0011: ndbps = 8'd216;
      default: ndbps = 8'd24;
    endcase
  endfunction

endpackage

// File: rtl/rx_frame_controller_if.sv
// Serial bit input and frame/PSDU output bundle of the receive frame controller.
interface rx_frame_controller_if;
  import rx_frame_controller_pkg::*;

  logic              iData;
  logic              iValid;
  logic              oData;
  logic              oValid;
  logic [RATE_W-1:0] oRate;
  logic [LEN_W-1:0]  oLength;
  logic              oHdrValid;
  logic              oHdrErr;
  logic              oSvcErr;
  logic              oDone;
  logic              oBusy;

  modport master (
    output iData, iValid,
    input  oData, oValid, oRate, oLength, oHdrValid, oHdrErr, oSvcErr, oDone, oBusy
  );

  modport slave (
    input  iData, iValid,
    output oData, oValid, oRate, oLength, oHdrValid, oHdrErr, oSvcErr, oDone, oBusy
  );
endinterface

// File: rtl/rx_frame_controller_descrambler.sv
// 7-bit x^7+x^4+1 descrambler: seed load from the received bits, then free-running descramble.
module rx_frame_controller_descrambler
  import rx_frame_controller_pkg::*;
(
  input  logic iClk,
  input  logic iRst,
  input  logic en,
  input  logic load,
  input  logic din,
  output logic dout_c
);

  logic [LFSR_W-1:0] s_q;
  logic              fb_c;

  assign fb_c   = s_q[6] ^ s_q[3];
  assign dout_c = din ^ fb_c;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s_q <= '0;
    end else if (en) begin
      s_q <= load ? {s_q[5:0], din} : {s_q[5:0], fb_c};
    end
  end

endmodule

// File: rtl/rx_frame_controller.sv
// Receive frame controller: preamble hunt, SIGNAL check, SERVICE seed recovery, PSDU descramble,
// TAIL/PAD discard up to the symbol boundary.
module rx_frame_controller
  import rx_frame_controller_pkg::*;
#(
  parameter logic [HDR_W-1:0] HEADER = HEADER_DEFAULT
) (
  input  logic                 iClk,
  input  logic                 iRst,
  rx_frame_controller_if.slave bus
);

  state_t                state_q, state_d;
  logic [HDR_W-2:0]      hunt_q, hunt_d;
  logic [HDR_W-1:0]      window_c;
  sig_hdr_t              sig_q, sig_d;
  logic                  par_q, par_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SYM_CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
  logic [SYM_CNT_W-1:0]  ndbps_q, ndbps_d;
  logic                  sticky_q, sticky_d;
  logic [RATE_W-1:0]     rate_q, rate_d;
  logic [LEN_W-1:0]      length_q, length_d;
  logic                  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  hdr_valid_q, hdr_valid_d;
  logic                  hdr_err_q, hdr_err_d;
  logic                  svc_err_q, svc_err_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic                  sym_wrap_c;
  logic                  hdr_ok_c;
  logic                  last_bit_c;
  logic                  ds_en_c, ds_load_c, ds_dout_c;

  // 11 bits of history plus the current bit form the 12-bit preamble window
  assign window_c   = {hunt_q, bus.iData};
  assign sym_wrap_c = (sym_cnt_q == ndbps_q - 8'd1);
  assign last_bit_c = (bit_cnt_q == '0);
  assign hdr_ok_c   = !par_q && !sig_q.rsvd && sig_q.rate[0] && (sig_q.length != '0);

  rx_frame_controller_descrambler u_descrambler (
    .iClk   (iClk),
    .iRst   (iRst),
    .en     (ds_en_c),
    .load   (ds_load_c),
    .din    (bus.iData),
    .dout_c (ds_dout_c)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= ST_HUNT;
      hunt_q      <= '0;
      sig_q       <= '0;
      par_q       <= 1'b0;
      bit_cnt_q   <= '0;
      sym_cnt_q   <= '0;
      ndbps_q     <= '0;
      sticky_q    <= 1'b0;
      rate_q      <= '0;
      length_q    <= '0;
      data_q      <= 1'b0;
      valid_q     <= 1'b0;
      hdr_valid_q <= 1'b0;
      hdr_err_q   <= 1'b0;
      svc_err_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hunt_q      <= hunt_d;
      sig_q       <= sig_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      ndbps_q     <= ndbps_d;
      sticky_q    <= sticky_d;
      rate_q      <= rate_d;
      length_q    <= length_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_err_q   <= hdr_err_d;
      svc_err_q   <= svc_err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hunt_d      = hunt_q;
    sig_d       = sig_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    ndbps_d     = ndbps_q;
    sticky_d    = sticky_q;
    rate_d      = rate_q;
    length_d    = length_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    hdr_valid_d = 1'b0;
    hdr_err_d   = 1'b0;
    svc_err_d   = 1'b0;
    done_d      = 1'b0;
    ds_en_c     = 1'b0;
    ds_load_c   = 1'b0;

    if (bus.iValid) begin
      // symbol counter runs from the first SERVICE bit to the end of the frame
      if (state_q inside {ST_SERVICE, ST_DATA, ST_TAIL, ST_PAD}) begin
        sym_cnt_d = sym_wrap_c ? '0 : sym_cnt_q + 8'd1;
      end

      case (state_q)
        ST_HUNT: begin
          hunt_d = window_c[HDR_W-2:0];
          if (window_c == HEADER) begin
            state_d   = ST_SIG;
            hunt_d    = '0;
            par_d     = 1'b0;
            bit_cnt_d = BIT_CNT_W'(SIG_LEN - 1);
          end
        end

        ST_SIG: begin
          par_d = par_q ^ bus.iData;
          if (last_bit_c) begin
            state_d   = ST_SIG_TAIL;
            bit_cnt_d = BIT_CNT_W'(TAIL_LEN - 1);
          end else begin
            sig_d     = sig_hdr_t'({sig_q[LEN_W+RATE_W-1:0], bus.iData});
            bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
          end
        end

        ST_SIG_TAIL: begin
          bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
          if (last_bit_c) begin
            if (hdr_ok_c) begin
              state_d     = ST_SERVICE;
              rate_d      = sig_q.rate;
              length_d    = sig_q.length;
              ndbps_d     = ndbps(sig_q.rate);
              sym_cnt_d   = '0;
              sticky_d    = 1'b0;
              bit_cnt_d   = BIT_CNT_W'(SVC_LEN - 1);
              hdr_valid_d = 1'b1;
            end else begin
              state_d   = ST_HUNT;
              bit_cnt_d = '0;
              hdr_err_d = 1'b1;
            end
            sig_d = '0;
          end
        end

        ST_SERVICE: begin
          ds_en_c   = 1'b1;
          ds_load_c = (bit_cnt_q >= BIT_CNT_W'(SVC_LEN - SEED_LEN));
          bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
          if (!ds_load_c) begin
            sticky_d = sticky_q | ds_dout_c;
          end
          if (last_bit_c) begin
            state_d   = ST_DATA;
            svc_err_d = sticky_q | ds_dout_c;
            bit_cnt_d = BIT_CNT_W'({length_q, 3'b000}) - BIT_CNT_W'(1);
          end
        end

        ST_DATA: begin
          ds_en_c   = 1'b1;
          data_d    = ds_dout_c;
          valid_d   = 1'b1;
          bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
          if (last_bit_c) begin
            state_d   = ST_TAIL;
            bit_cnt_d = BIT_CNT_W'(TAIL_LEN - 1);
          end
        end

        ST_TAIL: begin
          bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
          if (last_bit_c) begin
            bit_cnt_d = '0;
            if (sym_wrap_c) begin
              state_d = ST_HUNT;
              done_d  = 1'b1;
            end else begin
              state_d = ST_PAD;
            end
          end
        end

        ST_PAD: begin
          if (sym_wrap_c) begin
            state_d = ST_HUNT;
            done_d  = 1'b1;
          end
        end

        default: state_d = ST_HUNT;
      endcase
    end

    busy_d = (state_d != ST_HUNT);
  end

  assign bus.oData     = data_q;
  assign bus.oValid    = valid_q;
  assign bus.oRate     = rate_q;
  assign bus.oLength   = length_q;
  assign bus.oHdrValid = hdr_valid_q;
  assign bus.oHdrErr   = hdr_err_q;
  assign bus.oSvcErr   = svc_err_q;
  assign bus.oDone     = done_q;
  assign bus.oBusy     = busy_q;

endmodule

// File: tb/tb_rx_frame_controller.sv
// Bench for rx_frame_controller: frames are built from the field rules with a TX-side scrambler,
// and the recovered PSDU, header and frame pulses are compared against that reference.
module tb_rx_frame_controller;

  logic iClk = 1'b0;
  logic iRst = 1'b1;

  rx_frame_controller_if bus ();

  rx_frame_controller #(.HEADER(12'hFFF)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  always #5 iClk = ~iClk;

  int n_pass = 0;
  int n_chk  = 0;
  int n_hv = 0, n_he = 0, n_se = 0, n_dn = 0;
  int s_hv, s_he, s_se, s_dn;
  int unsigned cyc = 0, last_in_cyc = 0, done_cyc = 0;
  bit tx_q[$];
  bit exp_q[$];
  bit got_q[$];
  logic [3:0] rates [8] = '{4'b1101, 4'b1111, 4'b0101, 4'b0111,
                            4'b1001, 4'b1011, 4'b0001, 4'b0011};

  always @(posedge iClk) begin
    cyc <= cyc + 1;
    if (bus.iValid && !iRst) last_in_cyc <= cyc + 1;
  end

  always @(negedge iClk) begin
    if (bus.oValid)    got_q.push_back(bus.oData);
    if (bus.oHdrValid) n_hv++;
    if (bus.oHdrErr)   n_he++;
    if (bus.oSvcErr)   n_se++;
    if (bus.oDone) begin
      n_dn++;
      done_cyc = cyc;
    end
  end

  function automatic int nd(input logic [3:0] r);
    case (r)
      4'b1101: return 24;
      4'b1111: return 36;
      4'b0101: return 48;
      4'b0111: return 72;
      4'b1001: return 96;
      4'b1011: return 144;
      4'b0001: return 192;
      4'b0011: return 216;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Appends one transmitted frame to tx_q and its plaintext PSDU to exp_q
  task automatic build_frame(input logic [3:0] rate, input logic rsvd, input int len,
                             input bit bad_p, input int svc_flip, input bit full,
                             input bit use_pat, input logic [31:0] pat);
    logic [16:0] h;
    logic [6:0]  st;
    bit          b, fb;
    int          n, pad;
    for (int i = 0; i < 12; i++) tx_q.push_back(1'b1);
    h = {rate, rsvd, 12'(len)};
    for (int i = 16; i >= 0; i--) tx_q.push_back(h[i]);
    tx_q.push_back((^h) ^ bad_p);
    for (int i = 0; i < 6; i++) tx_q.push_back(bit'($urandom_range(0, 1)));
    if (!full) return;
    st = 7'b1011101;
    for (int i = 0; i < 16 + 8 * len; i++) begin
      if (i < 16) b = 1'b0;
      else begin
        b = use_pat ? pat[31 - (i - 16)] : bit'($urandom_range(0, 1));
        exp_q.push_back(b);
      end
      fb = st[6] ^ st[3];
      tx_q.push_back((b ^ fb) ^ (i == svc_flip));
      st = {st[5:0], fb};
    end
    for (int i = 0; i < 6; i++) tx_q.push_back(bit'($urandom_range(0, 1)));
    n   = 16 + 8 * len + 6;
    pad = (nd(rate) - (n % nd(rate))) % nd(rate);
    for (int i = 0; i < pad; i++) tx_q.push_back(bit'($urandom_range(0, 1)));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iClk);
      bus.iValid = 1'b0;
      bus.iData  = 1'b0;
    end
  endtask

  task automatic send_n(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap) begin
        @(negedge iClk);
        bus.iValid = 1'b0;
        bus.iData  = bit'($urandom_range(0, 1));
      end
      @(negedge iClk);
      bus.iValid = 1'b1;
      bus.iData  = tx_q[i];
    end
  endtask

  task automatic snap();
    s_hv = n_hv; s_he = n_he; s_se = n_se; s_dn = n_dn;
    got_q.delete();
  endtask

  task automatic run_good(input string tag, input logic [3:0] rate, input int len,
                          input int gap, input int svc_exp, input int nfr);
    bit same;
    snap();
    send_n(tx_q.size(), gap);
    idle(4);
    #1;
    same = (got_q.size() == exp_q.size());
    if (same) foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) same = 1'b0;
    chk({tag, " hdr_valid"}, n_hv - s_hv, nfr);
    chk({tag, " hdr_err"},   n_he - s_he, 0);
    chk({tag, " svc_err"},   n_se - s_se, svc_exp);
    chk({tag, " done"},      n_dn - s_dn, nfr);
    chk({tag, " done_cyc"},  done_cyc, last_in_cyc);
    chk({tag, " rate"},      32'(bus.oRate), 32'(rate));
    chk({tag, " length"},    32'(bus.oLength), len);
    chk({tag, " busy"},      32'(bus.oBusy), 0);
    chk({tag, " nbits"},     got_q.size(), exp_q.size());
    chk({tag, " data"},      32'(same), 1);
  endtask

  task automatic run_bad(input string tag, input logic [3:0] prev_rate, input int prev_len);
    snap();
    send_n(tx_q.size(), 0);
    idle(4);
    #1;
    chk({tag, " hdr_err"},   n_he - s_he, 1);
    chk({tag, " hdr_valid"}, n_hv - s_hv, 0);
    chk({tag, " rate"},      32'(bus.oRate), 32'(prev_rate));
    chk({tag, " length"},    32'(bus.oLength), prev_len);
    chk({tag, " busy"},      32'(bus.oBusy), 0);
    chk({tag, " nbits"},     got_q.size(), 0);
    chk({tag, " done"},      n_dn - s_dn, 0);
  endtask

  task automatic clr();
    tx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [3:0] r;
    int         l;
    bus.iData  = 1'b0;
    bus.iValid = 1'b0;

    // reset state
    idle(2);
    #1;
    chk("rst outputs", 32'({bus.oData, bus.oValid, bus.oRate, bus.oLength, bus.oHdrValid,
                            bus.oHdrErr, bus.oSvcErr, bus.oDone}), 0);
    chk("rst busy", 32'(bus.oBusy), 0);
    iRst = 1'b0;
    idle(2);
    #1;
    chk("post-rst outputs", 32'({bus.oValid, bus.oRate, bus.oLength, bus.oDone}), 0);

    // reference frame: RATE=1101, LENGTH=1, byte A5
    clr();
    build_frame(4'b1101, 1'b0, 1, 1'b0, -1, 1'b1, 1'b1, 32'hA500_0000);
    run_good("a5", 4'b1101, 1, 0, 0, 1);

    // header rejections keep the previous RATE/LENGTH
    clr(); build_frame(4'b1101, 1'b0, 1, 1'b1, -1, 1'b0, 1'b0, 32'h0);
    run_bad("bad_p", 4'b1101, 1);
    clr(); build_frame(4'b0100, 1'b0, 1, 1'b0, -1, 1'b0, 1'b0, 32'h0);
    run_bad("rate0100", 4'b1101, 1);
    clr(); build_frame(4'b1101, 1'b0, 0, 1'b0, -1, 1'b0, 1'b0, 32'h0);
    run_bad("len0", 4'b1101, 1);
    clr(); build_frame(4'b1101, 1'b1, 2, 1'b0, -1, 1'b0, 1'b0, 32'h0);
    run_bad("rsvd", 4'b1101, 1);

    // 11 ones and a zero must not lock
    clr();
    for (int i = 0; i < 11; i++) tx_q.push_back(1'b1);
    tx_q.push_back(1'b0);
    build_frame(4'b1111, 1'b0, 2, 1'b0, -1, 1'b1, 1'b0, 32'h0);
    run_good("partial", 4'b1111, 2, 0, 0, 1);

    // corrupted SERVICE bit 10
    clr();
    build_frame(4'b0101, 1'b0, 2, 1'b0, 10, 1'b1, 1'b0, 32'h0);
    run_good("svc10", 4'b0101, 2, 0, 1, 1);

    // identical output with iValid one cycle in three
    clr();
    build_frame(4'b1011, 1'b0, 3, 1'b0, -1, 1'b1, 1'b0, 32'h0);
    run_good("len3 dense", 4'b1011, 3, 0, 0, 1);
    run_good("len3 sparse", 4'b1011, 3, 2, 0, 1);

    // randomized frames
    for (int k = 0; k < 4; k++) begin
      r = rates[$urandom_range(0, 7)];
      l = $urandom_range(1, 4);
      clr();
      build_frame(r, 1'b0, l, 1'b0, -1, 1'b1, 1'b0, 32'h0);
      run_good("rand", r, l, $urandom_range(0, 1), 0, 1);
    end

    // back-to-back frames with no gap between them
    clr();
    build_frame(4'b1001, 1'b0, 2, 1'b0, -1, 1'b1, 1'b0, 32'h0);
    build_frame(4'b0001, 1'b0, 3, 1'b0, -1, 1'b1, 1'b0, 32'h0);
    run_good("b2b", 4'b0001, 3, 0, 0, 2);

    // reset in the middle of DATA
    clr();
    build_frame(4'b0111, 1'b0, 3, 1'b0, -1, 1'b1, 1'b0, 32'h0);
    s_dn = n_dn;
    send_n(64, 0);
    @(negedge iClk);
    bus.iValid = 1'b0;
    iRst       = 1'b1;
    @(negedge iClk);
    #1;
    chk("midrst outputs", 32'({bus.oData, bus.oValid, bus.oRate, bus.oLength, bus.oHdrValid,
                               bus.oHdrErr, bus.oSvcErr, bus.oDone}), 0);
    chk("midrst busy", 32'(bus.oBusy), 0);
    iRst = 1'b0;
    idle(3);
    #1;
    chk("midrst no done", n_dn - s_dn, 0);
    clr();
    build_frame(4'b1101, 1'b0, 2, 1'b0, -1, 1'b1, 1'b0, 32'h0);
    run_good("after rst", 4'b1101, 2, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_frame_controller.md
# rx_frame_controller

Receive-side frame controller that sits after the bit-recovery chain (deinterleaver and Viterbi decoder) and before the RX output FIFO. It hunts a serial bit stream for the PLCP preamble, then parses and checks the SIGNAL field and recovers the descrambler state from SERVICE. It emits the descrambled PSDU bits with a valid strobe, and discards TAIL and PAD bits so the next frame can be hunted.

## Interface
- `HEADER`, 12'hFFF, preamble pattern to match, MSB received first
- `iClk`  in  1  clock
- `iRst`  in  1  asynchronous, active-high reset
- `iData`  in  1  serial received bit
- `iValid`  in  1  `iData` is a new bit this cycle
- `oData`  out  1  descrambled PSDU bit
- `oValid`  out  1  `oData` valid, one pulse per PSDU bit
- `oRate`  out  4  RATE of the last accepted header
- `oLength`  out  12  LENGTH of the last accepted header, in bytes
- `oHdrValid`  out  1  one-cycle pulse: header accepted
- `oHdrErr`  out  1  one-cycle pulse: header rejected
- `oSvcErr`  out  1  one-cycle pulse: SERVICE bits 7..15 did not descramble to 0
- `oDone`  out  1  one-cycle pulse: frame fully consumed
- `oBusy`  out  1  high whenever state ≠ HUNT

## Operation
- Only cycles with `iValid`=1 consume a bit. With `iValid`=0, all state and counters hold.
- HUNT: shift each bit into a 12-bit register. On a match with `HEADER`, go to SIG. The register clears on leaving HUNT.
- SIG, 18 bits, MSB first:
  - RATE[3:0], then reserved (R), then LENGTH[11:0], then P.
  - P makes even parity over all 18 bits; a running XOR accumulates over the bits.
- SIG_TAIL, 6 bits: contents are ignored.
- Header accept/reject is evaluated on the 6th SIG_TAIL bit. The header is rejected if any of the following holds:
  - parity fails;
  - R=1;
  - RATE[0]=0;
  - LENGTH=0.
- Header accepted: go to SERVICE and latch `oRate`/`oLength`.
- Header rejected: go to HUNT. `oRate`/`oLength` are not updated.
- N_DBPS by RATE: 1101→24, 1111→36, 0101→48, 0111→72, 1001→96, 1011→144, 0001→192, 0011→216.
- SERVICE, 16 bits, using descrambler state s[6:0] with f=s[6]^s[3]:
  - Bits 0–6: s←{s[5:0],iData} (self-synchronising seed load). No output.
  - Bits 7–15: output d=iData^f, then s←{s[5:0],f}. If any d=1, set a sticky error bit.
  - `oSvcErr` pulses after bit 15 if the sticky bit is set. SERVICE is never output, and the frame continues regardless.
- DATA, 8·LENGTH bits: `oData`=iData^f and `oValid`=1; s advances as above.
- TAIL, 6 bits, then PAD: both are discarded.
- Symbol counter (8 bit): starts at 0 on the first SERVICE bit and wraps to 0 after N_DBPS−1.
- End of frame is the bit after which the symbol counter has wrapped to 0:
  - If that happens at the last TAIL bit, go straight to HUNT (PAD length 0).
  - Otherwise go to PAD and consume bits until the wrap, then go to HUNT.
  - `oDone` pulses at end of frame.
- Bit counter: 16 bit, loaded per state with the field length − 1, decrements on each consumed bit.

## Timing
- Reset values:
  - all outputs 0, including `oRate`/`oLength`;
  - state HUNT;
  - counters and s all 0.
- All outputs are registered. `oData`/`oValid` appear one cycle after the consuming edge.
- `oHdrValid`, `oHdrErr`, `oSvcErr` and `oDone` are high for exactly one cycle, one cycle after the consuming edge of the deciding bit.
- The preamble match enters SIG on the same edge as the 12th '1'. The next valid bit is RATE[3].
- Back-to-back frames: HUNT is active on the cycle after `oDone`. A preamble may start with the very next valid bit.
- Reset mid-frame immediately returns the block to reset values. No partial `oDone` is produced.

## Structure
- Shared package/include holds:
  - state encodings (HUNT, SIG, SIG_TAIL, SERVICE, DATA, TAIL, PAD);
  - the RATE→N_DBPS function;
  - `HEADER` default;
  - the field-length constants 18, 6 and 16.
- Sub-module `descrambler`: 7-bit LFSR with load-from-input mode and descramble mode.
  - Its polynomial is the same as the TX scrambler.
  - Its ports: clock, reset, enable, load, data in, data out.

## Test plan
- Preamble, then SIGNAL RATE=1101 with LENGTH=1 and correct parity, then TX-scrambled SERVICE/data byte 0xA5 (seed 7'b1011101), 6 tail bits and 18 pad bits. Required response:
  - `oHdrValid` pulses;
  - `oRate`=1101 and `oLength`=1;
  - 8 `oValid` pulses carrying 1,0,1,0,0,1,0,1;
  - `oDone` one cycle after the 48th post-SIGNAL bit.
- Same frame with P flipped → `oHdrErr` pulses, state is HUNT, `oRate`/`oLength` keep their previous values, no `oValid`.
- RATE=0100 → `oHdrErr`. LENGTH=0 → `oHdrErr`.
- 11 ones, a 0, then a full valid frame → no lock on the partial pattern; the frame that follows is received correctly.
- Corrupt SERVICE bit 10 → `oSvcErr` pulse, and data is still output correctly.
- `iValid` toggling 1-of-3 cycles through a LENGTH=3 frame → identical output bit sequence. Assert `iRst` mid-DATA → all outputs 0 and `oBusy`=0 on the next cycle; a subsequent frame is received correctly.
